// File: rtl/rcv_pkg.sv
// Shared types and constants for the serial packet receive controller.
package rcv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SYNC_WAIT,
    SYNC_CHK,
    DATA_WAIT,
    STORE,
    EOP_WAIT,
    ERR_DRAIN,
    ERR_EOP_WAIT,
    EIDLE
  } rcv_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

endpackage

// File: rtl/rcv_ctrl.sv
// Receive control FSM: sequences the bit/byte timer, validates SYNC,
// strobes FIFO writes per data byte and flags framing errors.
module rcv_ctrl
  import rcv_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       disable_timer
);

  rcv_state_t state_reg, state_next;
  logic [2:0] bit_cnt_reg;
  logic       eop_seen;

  // EOP is only meaningful when sampled on a bit strobe.
  assign eop_seen = shift_enable & eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= 3'd0;
    end else if (state_reg == START || state_reg == SYNC_CHK || state_reg == STORE) begin
      bit_cnt_reg <= 3'd0;
    end else if (state_reg == DATA_WAIT && shift_enable) begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:         if (d_edge) state_next = START;
      START:        state_next = SYNC_WAIT;
      SYNC_WAIT: begin
        if (byte_received)  state_next = SYNC_CHK;
        else if (eop_seen)  state_next = ERR_EOP_WAIT;
      end
      SYNC_CHK:     state_next = (rcv_data == SYNC_BYTE) ? DATA_WAIT : ERR_DRAIN;
      DATA_WAIT: begin
        // A byte boundary takes priority over a coincident EOP.
        if (byte_received)  state_next = STORE;
        else if (eop_seen)  state_next = (bit_cnt_reg == 3'd0) ? EOP_WAIT : ERR_EOP_WAIT;
      end
      STORE:        state_next = DATA_WAIT;
      EOP_WAIT:     if (d_edge) state_next = IDLE;
      ERR_DRAIN:    if (eop_seen) state_next = ERR_EOP_WAIT;
      ERR_EOP_WAIT: if (d_edge) state_next = EIDLE;
      EIDLE:        if (d_edge) state_next = START;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    rcving        = 1'b0;
    w_enable      = 1'b0;
    r_error       = 1'b0;
    disable_timer = 1'b0;
    unique case (state_reg)
      IDLE:         disable_timer = 1'b1;
      START, SYNC_WAIT, SYNC_CHK, DATA_WAIT: rcving = 1'b1;
      STORE: begin
        rcving   = 1'b1;
        w_enable = 1'b1;
      end
      EOP_WAIT: begin
        rcving        = 1'b1;
        disable_timer = 1'b1;
      end
      ERR_DRAIN: begin
        rcving  = 1'b1;
        r_error = 1'b1;
      end
      ERR_EOP_WAIT: begin
        rcving        = 1'b1;
        r_error       = 1'b1;
        disable_timer = 1'b1;
      end
      EIDLE: begin
        r_error       = 1'b1;
        disable_timer = 1'b1;
      end
      default:      disable_timer = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed bench for rcv_ctrl: walks good, bad-SYNC, premature/misaligned EOP,
// collision and mid-packet reset scenarios, checking outputs after each edge.
module tb_rcv_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       rcving, w_enable, r_error, disable_timer;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int we_base;

  rcv_ctrl #(.SYNC_BYTE(8'h80)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving), .w_enable(w_enable),
    .r_error(r_error), .disable_timer(disable_timer)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (w_enable === 1'b1) we_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic de, input logic se, input logic ep, input logic br);
    d_edge = de; shift_enable = se; eop = ep; byte_received = br;
    step();
    d_edge = 1'b0; shift_enable = 1'b0; eop = 1'b0; byte_received = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {rcving, w_enable, r_error, disable_timer};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: {rcving,w_enable,r_error,disable_timer} got %b expected %b", tag, obs, exp);
    end
    $display("step %-16s outputs=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
    $display("step %-16s value=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    // Reset
    step(); step();
    chk("reset", 4'b0001);
    rst = 1'b0;
    step();
    chk("idle_hold", 4'b0001);

    // Good packet
    we_base = we_count;
    pulse(1, 0, 0, 0);              chk("good_start", 4'b1000);
    step();                          chk("good_syncwait", 4'b1000);
    for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
    chk("good_shift", 4'b1000);
    rcv_data = 8'h80;
    pulse(0, 0, 0, 1);              chk("good_syncchk", 4'b1000);
    step();                          chk("good_datawait", 4'b1000);
    rcv_data = 8'hA5;
    pulse(0, 0, 0, 1);              chk("good_store1", 4'b1100);
    step();                          chk("good_after1", 4'b1000);
    for (int i = 0; i < 8; i++) pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);              chk("eop_no_strobe", 4'b1000);
    rcv_data = 8'h3C;
    pulse(0, 0, 0, 1);              chk("good_store2", 4'b1100);
    step();                          chk("good_after2", 4'b1000);
    pulse(0, 1, 1, 0);              chk("good_eopwait", 4'b1001);
    pulse(1, 0, 0, 0);              chk("good_idle", 4'b0001);
    chk_int("good_we_count", we_count - we_base, 2);

    // Bad SYNC
    we_base = we_count;
    pulse(1, 0, 0, 0);              chk("bad_start", 4'b1000);
    step();                          chk("bad_syncwait", 4'b1000);
    rcv_data = 8'h81;
    pulse(0, 0, 0, 1);              chk("bad_chk_1cyc", 4'b1000);
    step();                          chk("bad_drain_2cyc", 4'b1010);
    pulse(0, 1, 0, 0);              chk("bad_drain_hold", 4'b1010);
    pulse(0, 1, 1, 0);              chk("bad_erreop", 4'b1011);
    pulse(1, 0, 0, 0);              chk("bad_eidle", 4'b0011);
    step();                          chk("bad_eidle_hold", 4'b0011);
    pulse(1, 0, 0, 0);              chk("bad_restart", 4'b1000);
    chk_int("bad_we_count", we_count - we_base, 0);

    // Premature EOP (continues from START)
    step();                          chk("pre_syncwait", 4'b1000);
    pulse(0, 1, 1, 0);              chk("pre_erreop", 4'b1011);
    pulse(1, 0, 0, 0);              chk("pre_eidle", 4'b0011);

    // Misaligned EOP
    we_base = we_count;
    pulse(1, 0, 0, 0);              chk("mis_start", 4'b1000);
    step();
    rcv_data = 8'h80;
    pulse(0, 0, 0, 1);
    step();                          chk("mis_datawait", 4'b1000);
    rcv_data = 8'hA5;
    pulse(0, 0, 0, 1);              chk("mis_store", 4'b1100);
    step();
    for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
    pulse(0, 1, 1, 0);              chk("mis_erreop", 4'b1011);
    chk_int("mis_we_count", we_count - we_base, 1);
    pulse(1, 0, 0, 0);              chk("mis_eidle", 4'b0011);

    // Collision: byte_received wins over shift_enable&eop
    pulse(1, 0, 0, 0);
    step();
    rcv_data = 8'h80;
    pulse(0, 0, 0, 1);
    step();                          chk("col_datawait", 4'b1000);
    we_base = we_count;
    rcv_data = 8'h3C;
    pulse(0, 1, 1, 1);              chk("col_store", 4'b1100);
    step();                          chk("col_after", 4'b1000);
    chk_int("col_we_count", we_count - we_base, 1);
    pulse(1, 0, 0, 0);              chk("dedge_ignored", 4'b1000);

    // Reset mid-packet with a coincident byte strobe: byte is discarded
    we_base = we_count;
    rst = 1'b1;
    pulse(0, 0, 0, 1);
    rst = 1'b0;                      chk("rst_mid", 4'b0001);
    step(); step();                  chk("rst_idle", 4'b0001);
    chk_int("rst_we_count", we_count - we_base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
